// File: rtl/motor_ramp_pkg.sv
// Shared types and constants for the dual-channel motor duty ramp controller.
package motor_ramp_pkg;

    localparam int DUTY_W = 11;

    typedef enum logic [1:0] {
        CH_HOLD,
        CH_SLEW,
        CH_DWELL
    } chan_state_e;

    typedef enum logic {
        TOP_RUN,
        TOP_ESTOP
    } top_state_e;

endpackage

// File: rtl/motor_ramp_chan.sv
// One duty channel: slews its output toward the target in bounded steps per tick,
// passing through 0 and dwelling there before any sign reversal.
module motor_ramp_chan
    import motor_ramp_pkg::*;
#(
    parameter int STEP        = 8,
    parameter int DWELL_TICKS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clear,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty
);

    localparam int AW = DUTY_W + 1;
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam logic signed [AW-1:0] STEP_W = AW'(STEP);
    localparam logic signed [AW-1:0] ZERO_W = '0;

    chan_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic              pre_neg_q, pre_neg_d;

    logic signed [AW-1:0] out_w, tgt_w, diff_w, mag_w, step_w, next_w;
    logic                 opposite;

    // With an opposite-sign target the effective goal is 0, so one datapath covers both cases.
    always_comb begin
        out_w    = {duty_q[DUTY_W-1], duty_q};
        tgt_w    = {target[DUTY_W-1], target};
        opposite = ((out_w > ZERO_W) && (tgt_w < ZERO_W)) ||
                   ((out_w < ZERO_W) && (tgt_w > ZERO_W));
        diff_w   = opposite ? (ZERO_W - out_w) : (tgt_w - out_w);
        mag_w    = (diff_w < ZERO_W) ? (ZERO_W - diff_w) : diff_w;
        step_w   = (mag_w > STEP_W) ? STEP_W : mag_w;
        next_w   = (diff_w < ZERO_W) ? (out_w - step_w) : (out_w + step_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CH_HOLD;
            duty_q    <= '0;
            dwell_q   <= '0;
            pre_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            dwell_q   <= dwell_d;
            pre_neg_q <= pre_neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CH_HOLD: begin
                if (tgt_w != out_w) state_d = CH_SLEW;
            end
            CH_SLEW: begin
                if (tgt_w == out_w)                               state_d = CH_HOLD;
                else if (tick && (next_w == tgt_w))               state_d = CH_HOLD;
                else if (tick && opposite && (next_w == ZERO_W))  state_d = CH_DWELL;
            end
            CH_DWELL: begin
                if (tgt_w == ZERO_W)                           state_d = CH_HOLD;
                else if ((tgt_w < ZERO_W) == pre_neg_q)        state_d = CH_SLEW;
                else if (dwell_q == '0)                        state_d = CH_SLEW;
            end
            default: state_d = CH_HOLD;
        endcase
        if (clear) state_d = CH_HOLD;
    end

    // pre_neg remembers which side we came from so a return to that side can skip the dwell.
    always_comb begin
        duty_d    = duty_q;
        dwell_d   = dwell_q;
        pre_neg_d = pre_neg_q;
        case (state_q)
            CH_SLEW: begin
                if (tick) begin
                    duty_d = next_w[DUTY_W-1:0];
                    if (opposite && (next_w == ZERO_W)) begin
                        dwell_d   = DW'(DWELL_TICKS);
                        pre_neg_d = (out_w < ZERO_W);
                    end
                end
            end
            CH_DWELL: begin
                if (state_d != CH_DWELL) dwell_d = '0;
                else if (tick)           dwell_d = dwell_q - 1'b1;
            end
            default: ;
        endcase
        if (clear) begin
            duty_d    = '0;
            dwell_d   = '0;
            pre_neg_d = 1'b0;
        end
    end

    assign duty = duty_q;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Top of the motor duty ramp controller: tick divider, target handshake,
// emergency-stop FSM and two ramp channels.
module motor_ramp_ctrl
    import motor_ramp_pkg::*;
#(
    parameter int TICK_DIV    = 1024,
    parameter int STEP        = 8,
    parameter int DWELL_TICKS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [DUTY_W-1:0] cmd_lft,
    input  logic [DUTY_W-1:0] cmd_rht,
    input  logic              estop,
    output logic [DUTY_W-1:0] lft,
    output logic [DUTY_W-1:0] rht,
    output logic              at_target,
    output logic              busy
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0]     tick_cnt;
    logic              tick;
    top_state_e        state_q, state_d;
    logic [DUTY_W-1:0] tgt_lft, tgt_rht;
    logic              accept;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= TOP_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = estop ? TOP_ESTOP : TOP_RUN;
    end

    always_comb begin
        cmd_rdy   = (state_q == TOP_RUN);
        at_target = (lft == tgt_lft) && (rht == tgt_rht);
        busy      = !at_target || (state_q == TOP_ESTOP);
    end

    // A handshake that coincides with estop is swallowed; estop wins over any new target.
    assign accept = cmd_vld && cmd_rdy && !estop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_lft <= '0;
            tgt_rht <= '0;
        end else if (estop) begin
            tgt_lft <= '0;
            tgt_rht <= '0;
        end else if (accept) begin
            tgt_lft <= cmd_lft;
            tgt_rht <= cmd_rht;
        end
    end

    motor_ramp_chan #(
        .STEP        (STEP),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_chan_lft (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clear  (estop),
        .target (tgt_lft),
        .duty   (lft)
    );

    motor_ramp_chan #(
        .STEP        (STEP),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_chan_rht (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clear  (estop),
        .target (tgt_rht),
        .duty   (rht)
    );

endmodule
